// File: rtl/multicycle_ctrl_if.sv
// Control/bus bundle between multicycle_ctrl (master) and the datapath/memory port (slave).
// Handshake: mem_req is held high until the cycle in which mem_ready=1; that cycle completes the access.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_lt;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        pc_src;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        mem_to_reg;
    logic        link_sel;
    logic [1:0]  alu_op;
    logic        illegal;
    logic        bus_err;
    logic [31:0] instret;

    modport master (
        input  instr, alu_zero, alu_lt, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, reg_write, pc_src,
               alu_src_a, alu_src_b, mem_to_reg, link_sel, alu_op,
               illegal, bus_err, instret
    );

    modport slave (
        output instr, alu_zero, alu_lt, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, reg_write, pc_src,
               alu_src_a, alu_src_b, mem_to_reg, link_sel, alu_op,
               illegal, bus_err, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP over one shared memory port.
// Optional retired-instruction counter enabled by defining CTRL_INSTRET_EN.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_AUIPC  = 3'd5,
        C_JAL    = 3'd6,
        C_NONE   = 3'd7
    } cls_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic       TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t     r_state;
    state_t     w_state_next;
    cls_t       r_cls;
    cls_t       w_dec_cls;
    logic [1:0] r_br_kind;
    logic [7:0] r_wait;
    logic       r_illegal;
    logic       r_bus_err;

    logic       w_waiting;
    logic       w_timeout;
    logic       w_taken;
    logic       w_unused_instr_bits;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_pc_src;
    logic       w_alu_src_a;
    logic       w_alu_src_b;
    logic       w_mem_to_reg;
    logic       w_link_sel;
    logic [1:0] w_alu_op;

    assign w_unused_instr_bits = ^{bus.instr[31:15], bus.instr[13], bus.instr[11:7]};

    // Legal branch funct3 values (000/001/100/101) are exactly those with bit 1 clear.
    always_comb begin
        w_dec_cls = C_NONE;
        case (bus.instr[6:0])
            7'b0110011: w_dec_cls = C_R;
            7'b0010011: w_dec_cls = C_I;
            7'b0000011: w_dec_cls = C_LOAD;
            7'b0100011: w_dec_cls = C_STORE;
            7'b1100011: w_dec_cls = bus.instr[13] ? C_NONE : C_BRANCH;
            7'b0010111: w_dec_cls = C_AUIPC;
            7'b1101111: w_dec_cls = C_JAL;
            default:    w_dec_cls = C_NONE;
        endcase
    end

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
    assign w_timeout = TO_EN && w_waiting && ((r_wait + 8'd1) == TO_LIMIT);

    // r_br_kind = {funct3[2], funct3[0]}: bit 1 picks lt vs zero, bit 0 inverts the condition.
    assign w_taken = r_br_kind[1] ? (bus.alu_lt ^ r_br_kind[0]) : (bus.alu_zero ^ r_br_kind[0]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_FETCH;
            S_FETCH: begin
                if (w_timeout)          w_state_next = S_TRAP;
                else if (bus.mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: w_state_next = (w_dec_cls == C_NONE) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (r_cls)
                    C_R, C_I, C_AUIPC, C_JAL: w_state_next = S_WB;
                    C_LOAD, C_STORE:          w_state_next = S_MEM;
                    C_BRANCH:                 w_state_next = S_FETCH;
                    default:                  w_state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (w_timeout)          w_state_next = S_TRAP;
                else if (bus.mem_ready) w_state_next = (r_cls == C_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     w_state_next = S_FETCH;
            S_TRAP:   w_state_next = S_TRAP;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_link_sel   = 1'b0;
        w_alu_op     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_ir_write = bus.mem_ready;
            end
            S_EXEC: begin
                case (r_cls)
                    C_R:     w_alu_op = 2'b10;
                    C_I: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = 2'b10;
                    end
                    C_LOAD, C_STORE: w_alu_src_b = 1'b1;
                    C_AUIPC: begin
                        w_alu_src_a = 1'b1;
                        w_alu_src_b = 1'b1;
                    end
                    C_BRANCH: begin
                        w_alu_op   = 2'b01;
                        w_pc_write = 1'b1;
                        w_pc_src   = w_taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address operands stay as in EXEC so the ALU output is stable for the access.
                w_alu_src_b = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_we    = (r_cls == C_STORE);
                w_pc_write  = (r_cls == C_STORE) && bus.mem_ready;
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_mem_to_reg = (r_cls == C_LOAD);
                w_link_sel   = (r_cls == C_JAL);
                w_pc_src     = (r_cls == C_JAL);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cls     <= C_NONE;
            r_br_kind <= 2'b00;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_cls     <= w_dec_cls;
                r_br_kind <= {bus.instr[14], bus.instr[12]};
                if (w_dec_cls == C_NONE) r_illegal <= 1'b1;
            end
            // Any state change restarts the wait count, so each FETCH/MEM entry starts at 0.
            if (w_state_next != r_state) r_wait <= 8'd0;
            else if (w_waiting)          r_wait <= r_wait + 8'd1;
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_instret <= 32'd0;
        else if (w_pc_write) r_instret <= r_instret + 32'd1;
    end

    assign bus.instret = r_instret;
`else
    assign bus.instret = 32'd0;
`endif

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.link_sel   = w_link_sel;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal    = r_illegal;
    assign bus.bus_err    = r_bus_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction vector table plus reset, trap and timeout sequences.
// Inputs change and outputs are sampled in the low clock phase, well away from the rising edge.
module tb_multicycle_ctrl;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         n_tests;
    int         n_fail;
    int         retired;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.master),
        .o_dbg_state (dbg_state)
    );

    logic [13:0] all_out;
    assign all_out = {bus_if.mem_req, bus_if.mem_we, bus_if.ir_write, bus_if.pc_write,
                      bus_if.reg_write, bus_if.pc_src, bus_if.alu_src_a, bus_if.alu_src_b,
                      bus_if.mem_to_reg, bus_if.link_sel, bus_if.alu_op,
                      bus_if.illegal, bus_if.bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        lt;
        int          fetch_wait;
        int          mem_wait;
        logic        e_a;
        logic        e_b;
        logic [1:0]  e_op;
        logic        e_pcw;
        logic        e_pcsrc;
        logic [2:0]  e_after;
        logic        e_we;
        logic        e_m2r;
        logic        e_link;
        logic        e_wb_pcsrc;
        int          e_cycles;
    } vec_t;

    vec_t vecs[16];

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef CTRL_INSTRET_EN
        return 32'(retired);
`else
        return 32'd0;
`endif
    endfunction

    // Starts just after a falling edge with the FSM in FETCH; ends the same way.
    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        string tag;
        logic  go_wb;
        cyc = 0;
        tag = $sformatf("v%0d", idx);
        bus_if.instr    = v.instr;
        bus_if.alu_zero = v.zero;
        bus_if.alu_lt   = v.lt;
        for (int k = 0; k < v.fetch_wait; k++) begin
            bus_if.mem_ready = 1'b0;
            #1;
            chk_v({tag, "_fetch_wait_state"}, {29'd0, dbg_state}, {29'd0, ST_FETCH});
            chk_b({tag, "_fetch_wait_req"}, bus_if.mem_req, 1'b1);
            chk_b({tag, "_fetch_wait_irw"}, bus_if.ir_write, 1'b0);
            @(negedge clk); cyc++;
        end
        bus_if.mem_ready = 1'b1;
        #1;
        chk_v({tag, "_fetch_state"}, {29'd0, dbg_state}, {29'd0, ST_FETCH});
        chk_b({tag, "_fetch_req"}, bus_if.mem_req, 1'b1);
        chk_b({tag, "_fetch_we"}, bus_if.mem_we, 1'b0);
        chk_b({tag, "_fetch_irw"}, bus_if.ir_write, 1'b1);
        @(negedge clk); cyc++;
        #1;
        chk_v({tag, "_decode_state"}, {29'd0, dbg_state}, {29'd0, ST_DECODE});
        chk_b({tag, "_decode_req"}, bus_if.mem_req, 1'b0);
        chk_b({tag, "_decode_irw"}, bus_if.ir_write, 1'b0);
        @(negedge clk); cyc++;
        #1;
        chk_v({tag, "_exec_state"}, {29'd0, dbg_state}, {29'd0, ST_EXEC});
        chk_b({tag, "_exec_a"}, bus_if.alu_src_a, v.e_a);
        chk_b({tag, "_exec_b"}, bus_if.alu_src_b, v.e_b);
        chk_v({tag, "_exec_op"}, {30'd0, bus_if.alu_op}, {30'd0, v.e_op});
        chk_b({tag, "_exec_pcw"}, bus_if.pc_write, v.e_pcw);
        chk_b({tag, "_exec_pcsrc"}, bus_if.pc_src, v.e_pcsrc);
        chk_b({tag, "_exec_regw"}, bus_if.reg_write, 1'b0);
        chk_b({tag, "_exec_req"}, bus_if.mem_req, 1'b0);
        @(negedge clk); cyc++;
        go_wb = (v.e_after == ST_WB);
        if (v.e_after == ST_MEM) begin
            for (int k = 0; k < v.mem_wait; k++) begin
                bus_if.mem_ready = 1'b0;
                #1;
                chk_v({tag, "_memw_state"}, {29'd0, dbg_state}, {29'd0, ST_MEM});
                chk_b({tag, "_memw_req"}, bus_if.mem_req, 1'b1);
                chk_b({tag, "_memw_we"}, bus_if.mem_we, v.e_we);
                chk_b({tag, "_memw_b"}, bus_if.alu_src_b, 1'b1);
                chk_b({tag, "_memw_pcw"}, bus_if.pc_write, 1'b0);
                @(negedge clk); cyc++;
            end
            bus_if.mem_ready = 1'b1;
            #1;
            chk_v({tag, "_mem_state"}, {29'd0, dbg_state}, {29'd0, ST_MEM});
            chk_b({tag, "_mem_req"}, bus_if.mem_req, 1'b1);
            chk_b({tag, "_mem_we"}, bus_if.mem_we, v.e_we);
            chk_b({tag, "_mem_a"}, bus_if.alu_src_a, v.e_a);
            chk_v({tag, "_mem_op"}, {30'd0, bus_if.alu_op}, {30'd0, v.e_op});
            chk_b({tag, "_mem_pcw"}, bus_if.pc_write, v.e_we);
            chk_b({tag, "_mem_pcsrc"}, bus_if.pc_src, 1'b0);
            @(negedge clk); cyc++;
            go_wb = !v.e_we;
        end
        if (go_wb) begin
            #1;
            chk_v({tag, "_wb_state"}, {29'd0, dbg_state}, {29'd0, ST_WB});
            chk_b({tag, "_wb_regw"}, bus_if.reg_write, 1'b1);
            chk_b({tag, "_wb_pcw"}, bus_if.pc_write, 1'b1);
            chk_b({tag, "_wb_m2r"}, bus_if.mem_to_reg, v.e_m2r);
            chk_b({tag, "_wb_link"}, bus_if.link_sel, v.e_link);
            chk_b({tag, "_wb_pcsrc"}, bus_if.pc_src, v.e_wb_pcsrc);
            @(negedge clk); cyc++;
        end
        retired++;
        #1;
        chk_v({tag, "_back_to_fetch"}, {29'd0, dbg_state}, {29'd0, ST_FETCH});
        chk_v({tag, "_cycles"}, 32'(cyc), 32'(v.e_cycles));
        chk_v({tag, "_instret"}, bus_if.instret, exp_instret());
        chk_b({tag, "_no_flags"}, bus_if.illegal | bus_if.bus_err, 1'b0);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge; leaves FSM in FETCH.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_v({tag, "_rst_outputs"}, {18'd0, all_out}, 32'd0);
        chk_v({tag, "_rst_state"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
        chk_v({tag, "_rst_instret"}, bus_if.instret, 32'd0);
        retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_illegal(input logic [31:0] ins, input string tag);
        bus_if.instr     = ins;
        bus_if.mem_ready = 1'b1;
        #1;
        chk_b({tag, "_fetch_irw"}, bus_if.ir_write, 1'b1);
        @(negedge clk);
        #1;
        chk_v({tag, "_decode_state"}, {29'd0, dbg_state}, {29'd0, ST_DECODE});
        @(negedge clk);
        #1;
        chk_v({tag, "_trap_state"}, {29'd0, dbg_state}, {29'd0, ST_TRAP});
        chk_b({tag, "_illegal"}, bus_if.illegal, 1'b1);
        chk_b({tag, "_bus_err"}, bus_if.bus_err, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus_if.mem_ready = k[0];
            @(negedge clk);
            #1;
            chk_v({tag, "_trap_quiet"}, {18'd0, all_out}, 32'h2);
            chk_v({tag, "_trap_hold"}, {29'd0, dbg_state}, {29'd0, ST_TRAP});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        retired = 0;
        //          instr         z     lt    fw mw a     b     op     pcw   pcsrc after     we    m2r   link  wbpc  cyc
        vecs[0]  = '{32'h002081B3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, ST_WB,    1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[1]  = '{32'h00500093, 1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, ST_WB,    1'b0, 1'b0, 1'b0, 1'b0, 5};
        vecs[2]  = '{32'h0000A103, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, ST_MEM,   1'b0, 1'b1, 1'b0, 1'b0, 8};
        vecs[3]  = '{32'h0020A023, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, ST_MEM,   1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[4]  = '{32'h0020A023, 1'b0, 1'b1, 3, 3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, ST_MEM,   1'b1, 1'b0, 1'b0, 1'b0, 10};
        vecs[5]  = '{32'h0000A103, 1'b1, 1'b1, 2, 3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, ST_MEM,   1'b0, 1'b1, 1'b0, 1'b0, 10};
        vecs[6]  = '{32'h00208463, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[7]  = '{32'h00208463, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[8]  = '{32'h00209463, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[9]  = '{32'h00209463, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[10] = '{32'h0020C463, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[11] = '{32'h0020C463, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[12] = '{32'h0020D463, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[13] = '{32'h0020D463, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[14] = '{32'h00000117, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, ST_WB,    1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[15] = '{32'h008000EF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ST_WB,    1'b0, 1'b0, 1'b1, 1'b1, 4};

        rst_n            = 1'b0;
        bus_if.instr     = 32'd0;
        bus_if.alu_zero  = 1'b0;
        bus_if.alu_lt    = 1'b0;
        bus_if.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_v("reset_outputs", {18'd0, all_out}, 32'd0);
        chk_v("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        chk_v("reset_instret", bus_if.instret, 32'd0);
        rst_n = 1'b1;
        #1;
        chk_v("idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        chk_v("idle_outputs", {18'd0, all_out}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        run_illegal(32'h0000007F, "illegal_op");
        do_reset("after_illegal");
        run_illegal(32'h0020A463, "illegal_br_f3");
        do_reset("after_br_f3");

        // Fetch never acknowledged: four wait cycles, then TRAP with bus_err.
        bus_if.instr     = 32'h002081B3;
        bus_if.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_v("to_fetch_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
            chk_b("to_fetch_req", bus_if.mem_req, 1'b1);
            chk_b("to_fetch_no_err", bus_if.bus_err, 1'b0);
            @(negedge clk);
        end
        #1;
        chk_v("to_fetch_trap", {29'd0, dbg_state}, {29'd0, ST_TRAP});
        chk_v("to_fetch_flags", {18'd0, all_out}, 32'h1);
        bus_if.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk_v("to_fetch_trap_hold", {18'd0, all_out}, 32'h1);
        do_reset("after_fetch_to");

        // Load stuck in MEM: four wait cycles, then TRAP.
        bus_if.instr     = 32'h0000A103;
        bus_if.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_v("to_mem_state", {29'd0, dbg_state}, {29'd0, ST_MEM});
            chk_b("to_mem_no_err", bus_if.bus_err, 1'b0);
            @(negedge clk);
        end
        #1;
        chk_v("to_mem_trap", {29'd0, dbg_state}, {29'd0, ST_TRAP});
        chk_v("to_mem_flags", {18'd0, all_out}, 32'h1);
        do_reset("after_mem_to");

        // Reset asserted in the middle of a MEM wait, no clock edge before sampling.
        bus_if.instr     = 32'h0000A103;
        bus_if.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk_v("midwait_state", {29'd0, dbg_state}, {29'd0, ST_MEM});
        chk_b("midwait_req", bus_if.mem_req, 1'b1);
        do_reset("midwait");

        run_vec(vecs[0], 100);
        run_vec(vecs[2], 102);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
